div8_seq: RTL and testbench

Sequential 8-bit integer divider for the RV32 ALU datapath, issuing one restoring subtract step per clock. It takes dividend/divisor operands from the operand-select stage and returns quotient and remainder to the writeback mux. Results follow RISC-V DIV/DIVU/REM/REMU semantics, including the divide-by-zero and signed-overflow cases. The design uses valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 17 +
 rtl/div8_seq_if.sv | 29 ++
 rtl/div8_sub_step.sv | 27 ++
 rtl/div8_seq.sv | 153 +++++++++++++++
 tb/tb_div8_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default width and the
// operand patterns that select the divide-by-zero and signed-overflow paths.
package alu_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [W_DEFAULT-1:0] ALL_ONES = {W_DEFAULT{1'b1}};
  localparam logic [W_DEFAULT-1:0] MOST_NEG = {1'b1, {(W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/div8_seq_if.sv
// Operand/result handshake bundle between the operand-select stage,
// the sequential divider and the writeback mux.
interface div8_seq_if
  import alu_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;
  logic         ovf;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );
endinterface

// File: rtl/div8_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude if it fits.
module div8_sub_step
  import alu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] rem,
  input  logic         shift_in,
  input  logic [W-1:0] dmag,
  output logic [W-1:0] rem_next,
  output logic         q_bit,
  output logic         borrow
);

  // One guard bit above the W+1-bit trial turns the sign of the difference
  // into a plain bit; since rem < dmag, the trial never legitimately sets bit W.
  logic [W+1:0] trial;

  always_comb begin
    trial    = {1'b0, rem, shift_in} - {2'b00, dmag};
    borrow   = trial[W+1] | trial[W];
    q_bit    = ~borrow;
    rem_next = borrow ? {rem[W-2:0], shift_in} : trial[W-1:0];
  end

endmodule

// File: rtl/div8_seq.sv
// Sequential W-bit divider with RISC-V DIV/DIVU/REM/REMU semantics:
// one restoring step per clock, then a single sign-fixup cycle.
module div8_seq
  import alu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  div8_seq_if.slave  bus
);

  localparam int CW = $clog2(W) + 1;

  div_state_e    state_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  rem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  dmag_reg;
  logic          neg_q_reg;
  logic          neg_r_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic [W-1:0]  quotient_reg;
  logic [W-1:0]  remainder_reg;
  logic          dz_reg;
  logic          ovf_reg;

  logic          dividend_neg;
  logic          divisor_neg;
  logic [W-1:0]  dividend_mag;
  logic [W-1:0]  divisor_mag;
  logic [W-1:0]  rem_next;
  logic          q_bit;
  logic          borrow;

  always_comb begin
    dividend_neg = bus.is_signed & bus.dividend[W-1];
    divisor_neg  = bus.is_signed & bus.divisor[W-1];
    dividend_mag = dividend_neg ? -bus.dividend : bus.dividend;
    divisor_mag  = divisor_neg  ? -bus.divisor  : bus.divisor;
  end

  // The next dividend bit to enter the remainder is the MSB of the
  // quotient shift register; the freed LSB collects the quotient bit.
  div8_sub_step #(.W(W)) u_step (
    .rem      (rem_reg),
    .shift_in (quo_reg[W-1]),
    .dmag     (dmag_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit),
    .borrow   (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dmag_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            dz_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            if (bus.divisor == '0) begin
              quotient_reg  <= ALL_ONES;
              remainder_reg <= bus.dividend;
              dz_reg        <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (bus.is_signed && bus.dividend == MOST_NEG &&
                         bus.divisor == ALL_ONES) begin
              quotient_reg  <= bus.dividend;
              remainder_reg <= '0;
              ovf_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              quo_reg   <= dividend_mag;
              dmag_reg  <= divisor_mag;
              rem_reg   <= '0;
              count_reg <= '0;
              neg_q_reg <= dividend_neg ^ divisor_neg;
              neg_r_reg <= dividend_neg;
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          rem_reg   <= rem_next;
          quo_reg   <= {quo_reg[W-2:0], q_bit};
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(W - 1)) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          // Remainder takes the dividend's sign, quotient truncates toward zero.
          quotient_reg  <= neg_q_reg ? -quo_reg : quo_reg;
          remainder_reg <= neg_r_reg ? -rem_reg : rem_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.dz        = dz_reg;
  assign bus.ovf       = ovf_reg;

  // Accept and deliver are mutually exclusive, and both flags never rise together.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(in_ready_reg && out_valid_reg));
  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    in_ready_reg == (state_reg == IDLE));
  a_valid_done: assert property (@(posedge clk) disable iff (rst)
    out_valid_reg == (state_reg == DONE));
  a_one_flag: assert property (@(posedge clk) disable iff (rst)
    !(dz_reg && ovf_reg));

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed cases from the divider's corner
// behaviour plus randomized operations against an arithmetic reference model.
module tb_div8_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div8_seq_if #(.W(8)) bus ();

  div8_seq #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: RISC-V division rules using integer arithmetic (truncating).
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic edz, output logic eovf, output int elat);
    int sa, sb;
    edz = 1'b0; eovf = 1'b0; elat = 9;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; edz = 1'b1; elat = 0;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q = a; r = 8'h00; eovf = 1'b1; elat = 0;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives one operation from a falling edge; returns observed results and the
  // number of rising edges from the accept edge until out_valid is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit do_release,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic odz, output logic oovf,
                        output int lat, output int acc_cyc);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    acc_cyc       = cyc;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q    = bus.quotient;
    r    = bus.remainder;
    odz  = bus.dz;
    oovf = bus.ovf;
    $display("op %02h / %02h signed=%0d -> q=%02h r=%02h dz=%b ovf=%b lat=%0d",
             a, b, s, q, r, odz, oovf, lat);
    if (do_release) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = 8'h00; bus.divisor = 8'h00; bus.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00) begin errors++; $display("FAIL reset_results: got q=%02h r=%02h required 00/00", bus.quotient, bus.remainder); end
    checks++; if (bus.dz !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_flags: got dz=%b ovf=%b required 0/0", bus.dz, bus.ovf); end
  endtask

  task automatic test_unsigned();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    run_op(8'd100, 8'd7, 1'b0, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'h0E || r !== 8'h02) begin errors++; $display("FAIL udiv_100_7: got q=%02h r=%02h required 0e/02", q, r); end
    checks++; if (fdz !== 1'b0 || fovf !== 1'b0) begin errors++; $display("FAIL udiv_flags: got dz=%b ovf=%b required 0/0", fdz, fovf); end
    checks++; if (lat != 9) begin errors++; $display("FAIL udiv_latency: got %0d edges required 9", lat); end
  endtask

  task automatic test_signed();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    run_op(8'h9C, 8'h07, 1'b1, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'hF2 || r !== 8'hFE) begin errors++; $display("FAIL sdiv_m100_7: got q=%02h r=%02h required f2/fe", q, r); end
    run_op(8'd100, 8'hF9, 1'b1, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'hF2 || r !== 8'h02) begin errors++; $display("FAIL sdiv_100_m7: got q=%02h r=%02h required f2/02", q, r); end
    checks++; if (fdz !== 1'b0 || fovf !== 1'b0 || lat != 9) begin errors++; $display("FAIL sdiv_flags_lat: got dz=%b ovf=%b lat=%0d required 0/0/9", fdz, fovf, lat); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    for (int s = 0; s < 2; s++) begin
      run_op(8'h05, 8'h00, 1'(s), 1'b1, q, r, fdz, fovf, lat, acc);
      checks++; if (q !== 8'hFF || r !== 8'h05) begin errors++; $display("FAIL dz_results s=%0d: got q=%02h r=%02h required ff/05", s, q, r); end
      checks++; if (fdz !== 1'b1 || fovf !== 1'b0) begin errors++; $display("FAIL dz_flags s=%0d: got dz=%b ovf=%b required 1/0", s, fdz, fovf); end
      checks++; if (lat != 0) begin errors++; $display("FAIL dz_latency s=%0d: got %0d edges required 0", s, lat); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    run_op(8'h80, 8'hFF, 1'b1, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'h80 || r !== 8'h00) begin errors++; $display("FAIL ovf_results: got q=%02h r=%02h required 80/00", q, r); end
    checks++; if (fovf !== 1'b1 || fdz !== 1'b0 || lat != 0) begin errors++; $display("FAIL ovf_flags_lat: got ovf=%b dz=%b lat=%0d required 1/0/0", fovf, fdz, lat); end
    run_op(8'h80, 8'hFF, 1'b0, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'h00 || r !== 8'h80) begin errors++; $display("FAIL unsigned_128_255: got q=%02h r=%02h required 00/80", q, r); end
    checks++; if (fovf !== 1'b0 || fdz !== 1'b0 || lat != 9) begin errors++; $display("FAIL unsigned_128_255_flags: got ovf=%b dz=%b lat=%0d required 0/0/9", fovf, fdz, lat); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    run_op(8'd200, 8'd3, 1'b0, 1'b0, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'h42 || r !== 8'h02) begin errors++; $display("FAIL bp_results: got q=%02h r=%02h required 42/02", q, r); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.quotient !== 8'h42 || bus.remainder !== 8'h02) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b q=%02h r=%02h required 1/0/42/02",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b v=%b required 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r; logic fdz, fovf; int lat, acc;
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.is_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_handshake: got rdy=%b v=%b required 1/0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00 || bus.dz !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got q=%02h r=%02h dz=%b ovf=%b required zeros", bus.quotient, bus.remainder, bus.dz, bus.ovf); end
    run_op(8'd9, 8'd3, 1'b0, 1'b1, q, r, fdz, fovf, lat, acc);
    checks++; if (q !== 8'h03 || r !== 8'h00 || lat != 9) begin errors++; $display("FAIL midrst_next: got q=%02h r=%02h lat=%0d required 03/00/9", q, r, lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r, eq, er; logic fdz, fovf, edz, eovf; int lat, elat, acc, prev_acc;
    logic [7:0] a, b; logic s;
    bus.out_ready = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom_range(1, 255)); s = 1'($urandom);
      model(a, b, s, eq, er, edz, eovf, elat);
      run_op(a, b, s, 1'b0, q, r, fdz, fovf, lat, acc);
      checks++; if (q !== eq || r !== er || lat != elat) begin errors++; $display("FAIL b2b_result %0d: got q=%02h r=%02h lat=%0d required %02h/%02h/%0d", i, q, r, lat, eq, er, elat); end
      if (prev_acc >= 0) begin
        checks++; if (acc - prev_acc != 11) begin errors++; $display("FAIL b2b_period %0d: got %0d cycles required 11", i, acc - prev_acc); end
      end
      prev_acc = acc;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_done_one_cycle %0d: got v=%b rdy=%b required 0/1", i, bus.out_valid, bus.in_ready); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q, r, eq, er; logic fdz, fovf, edz, eovf; int lat, elat, acc;
    logic [7:0] a, b; logic s; int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 7);
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      if (kind == 0) b = 8'h00;
      if (kind == 1) begin a = 8'h80; b = 8'hFF; end
      model(a, b, s, eq, er, edz, eovf, elat);
      run_op(a, b, s, 1'b1, q, r, fdz, fovf, lat, acc);
      checks++;
      if (q !== eq || r !== er || fdz !== edz || fovf !== eovf || lat != elat) begin
        errors++;
        $display("FAIL rand %0d %02h/%02h s=%0d: got q=%02h r=%02h dz=%b ovf=%b lat=%0d required %02h/%02h/%b/%b/%0d",
                 i, a, b, s, q, r, fdz, fovf, lat, eq, er, edz, eovf, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
